// File: rtl/pmod16led_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pmod16led_arb
//  Purpose  : Round-robin arbiter that lets one of four sources at a time
//             drive two 8-LED PMOD modules. A grantee keeps the display for
//             at least HOLD_TICKS dwell ticks. After that it is rotated out
//             if anyone else is waiting. A grantee that drops its request
//             loses the display at once.
//  Ports    : clk           system clock, all state on posedge
//             rst_n         asynchronous active-low reset
//             req[3:0]      per-source display request
//             pat0..pat3    16-bit LED pattern of each source
//             pmodled1[0:7] LEDs D1-D8  = granted pattern bits 0..7
//             pmodled2[0:7] LEDs D9-D16 = granted pattern bits 8..15
//             gnt[3:0]      one-hot grant, zero when idle
//             tick          one-cycle dwell-tick strobe
//  Revision : 1.0  initial release
// ============================================================================
module pmod16led_arb #(
    parameter logic [22:0] CLK_DIV    = 23'd6000000,
    parameter logic [3:0]  HOLD_TICKS = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] pat0,
    input  logic [15:0] pat1,
    input  logic [15:0] pat2,
    input  logic [15:0] pat3,
    output logic [0:7]  pmodled1,
    output logic [0:7]  pmodled2,
    output logic [3:0]  gnt,
    output logic        tick
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [22:0] c_presc_last = CLK_DIV - 23'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [22:0] r_presc;
    logic [3:0]  r_dwell;
    logic [3:0]  w_dwell_nxt;
    logic [1:0]  r_last;
    logic [1:0]  w_last_nxt;
    logic [3:0]  w_gnt_nxt;
    logic [2:0]  w_pick;       // {hit, index}
    logic [15:0] w_pat;

    // Round-robin search: offsets last+1, last+2, last+3, last (mod 4).
    // Scanning from the farthest offset down lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = l + i[1:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_pick = rr_pick(req, r_last);

    // Free-running prescaler; tick is high for the cycle after the wrap point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 23'd0;
            tick    <= 1'b0;
        end else begin
            tick    <= (r_presc == c_presc_last);
            r_presc <= (r_presc == c_presc_last) ? 23'd0 : r_presc + 23'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dwell <= 4'd0;
            r_last  <= 2'd3;
            gnt     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_last  <= w_last_nxt;
            gnt     <= w_gnt_nxt;
        end
    end

    // r_last always names the current grantee while in SHOW.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_last_nxt  = r_last;
        w_gnt_nxt   = gnt;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt   = 4'd0;
                w_dwell_nxt = 4'd0;
                if (w_pick[2]) begin
                    w_state_nxt = ST_SHOW;
                    w_gnt_nxt   = 4'd1 << w_pick[1:0];
                    w_last_nxt  = w_pick[1:0];
                end
            end
            ST_SHOW: begin
                if (!req[r_last]) begin
                    // Grantee withdrew; the search cannot return it since
                    // its own request bit is clear.
                    w_dwell_nxt = 4'd0;
                    if (w_pick[2]) begin
                        w_gnt_nxt  = 4'd1 << w_pick[1:0];
                        w_last_nxt = w_pick[1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 4'd0;
                    end
                end else if (r_dwell == HOLD_TICKS) begin
                    // Another requester is found before wrapping back to us.
                    if ((req & ~gnt) != 4'd0) begin
                        w_gnt_nxt   = 4'd1 << w_pick[1:0];
                        w_last_nxt  = w_pick[1:0];
                        w_dwell_nxt = 4'd0;
                    end
                end else if (tick) begin
                    w_dwell_nxt = r_dwell + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'd0;
                w_dwell_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_pat = 16'h0000;
        case (gnt)
            4'b0001: w_pat = pat0;
            4'b0010: w_pat = pat1;
            4'b0100: w_pat = pat2;
            4'b1000: w_pat = pat3;
            default: w_pat = 16'h0000;
        endcase
    end

    // LED ports are declared [0:7]; map bit by bit so LED k shows pattern bit k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmodled1 <= 8'd0;
            pmodled2 <= 8'd0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                pmodled1[k] <= w_pat[k];
                pmodled2[k] <= w_pat[8+k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmod16led_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmod16led_arb
//  Purpose  : Self-checking bench for pmod16led_arb (CLK_DIV=4, HOLD_TICKS=2)
//             with directed scenarios followed by random requests/patterns,
//             compared every cycle against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmod16led_arb;

    localparam int c_div  = 4;
    localparam int c_hold = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] pat0, pat1, pat2, pat3;
    logic [0:7]  pmodled1, pmodled2;
    logic [3:0]  gnt;
    logic        tick;

    pmod16led_arb #(.CLK_DIV(23'd4), .HOLD_TICKS(4'd2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .pat0     (pat0),
        .pat1     (pat1),
        .pat2     (pat2),
        .pat3     (pat3),
        .pmodled1 (pmodled1),
        .pmodled2 (pmodled2),
        .gnt      (gnt),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner index (-1 = nobody), last grant, dwell, prescaler.
    int          m_owner, m_last, m_dwell, m_cnt;
    bit          m_tick;
    logic [15:0] m_led;

    // Pre-emption watch, driven only by observed DUT outputs.
    logic [3:0] prev_gnt;
    int         tick_cnt;
    bit         prev_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat_of(input int i);
        case (i)
            0: return pat0;
            1: return pat1;
            2: return pat2;
            default: return pat3;
        endcase
    endfunction

    function automatic int rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [0:7] led_bits(input logic [7:0] v);
        logic [0:7] e;
        for (int k = 0; k < 8; k++) e[k] = v[k];
        return e;
    endfunction

    task automatic m_reset();
        m_owner = -1; m_last = 3; m_dwell = 0; m_cnt = 0; m_tick = 0; m_led = '0;
        prev_gnt = '0; tick_cnt = 0; prev_tick = 0;
    endtask

    task automatic m_update();
        int nxt;
        m_led = (m_owner < 0) ? 16'h0 : pat_of(m_owner);
        if (m_owner < 0) begin
            nxt = rr(req, m_last);
            if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_dwell = 0; end
        end else if (!req[m_owner]) begin
            nxt = rr(req, m_last);
            m_dwell = 0;
            if (nxt >= 0) begin m_owner = nxt; m_last = nxt; end
            else m_owner = -1;
        end else if (m_dwell == c_hold) begin
            if ((req & ~(4'b0001 << m_owner)) != 4'd0) begin
                nxt = rr(req, m_last);
                m_owner = nxt; m_last = nxt; m_dwell = 0;
            end
        end else if (m_tick) begin
            m_dwell++;
        end
        m_tick = (m_cnt == c_div - 1);
        m_cnt  = (m_cnt + 1) % c_div;
    endtask

    task automatic cycle();
        logic [3:0] req_e;
        logic [3:0] eg;
        @(posedge clk);
        req_e = req;
        if (rst_n) m_update(); else m_reset();
        @(negedge clk);
        eg = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("led1", 32'(pmodled1), 32'(led_bits(m_led[7:0])));
        chk("led2", 32'(pmodled2), 32'(led_bits(m_led[15:8])));
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (gnt !== prev_gnt) begin
            if (prev_gnt != 4'd0 && gnt != 4'd0 && (req_e & prev_gnt) != 4'd0)
                chk("no_preempt", 32'((tick_cnt - int'(prev_tick)) >= c_hold), 32'd1);
            tick_cnt = 0;
        end
        tick_cnt += int'(tick);
        prev_tick = tick;
        prev_gnt  = gnt;
    endtask

    initial begin
        int changes;
        logic [3:0] g_old;
        rst_n = 1'b0;
        req   = 4'd0;
        pat0  = 16'h1234; pat1 = 16'h5678; pat2 = 16'h9ABC; pat3 = 16'hDEF0;
        m_reset();
        repeat (3) cycle();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_led1", 32'(pmodled1), 32'd0);

        // First arbitration after reset favours source 0.
        rst_n = 1'b1;
        req   = 4'b0101;
        cycle();
        chk("r28_gnt", 32'(gnt), 32'b0001);
        cycle();
        chk("r28_led1", 32'(pmodled1), 32'(led_bits(8'h34)));
        chk("r28_led2", 32'(pmodled2), 32'(led_bits(8'h12)));

        // Two requesters alternate.
        req = 4'b0011;
        changes = 0;
        for (int i = 0; i < 48; i++) begin
            g_old = gnt;
            cycle();
            if (gnt != g_old) changes++;
        end
        chk("r29_alternations", 32'(changes >= 3), 32'd1);

        // Grantee drops at dwell 0, then everyone drops.
        req = 4'd0;
        repeat (2) cycle();
        req = 4'b0100;
        cycle();
        chk("r30_gnt2", 32'(gnt), 32'b0100);
        req = 4'b1000;
        cycle();
        chk("r30_gnt3", 32'(gnt), 32'b1000);
        req = 4'd0;
        cycle();
        chk("r30_idle", 32'(gnt), 32'd0);
        cycle();
        chk("r30_led_off", 32'({pmodled1, pmodled2}), 32'd0);

        // Single requester held for 20 ticks.
        req = 4'b1000;
        cycle();
        for (int i = 0; i < 80; i++) begin
            cycle();
            chk("r31_hold", 32'(gnt), 32'b1000);
        end

        // Reset mid-SHOW.
        pat1 = 16'hA5C3;
        req  = 4'b0010;
        repeat (3) cycle();
        chk("r32_pre", 32'(gnt), 32'b0010);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("r32_async_gnt", 32'(gnt), 32'd0);
        chk("r32_async_led", 32'({pmodled1, pmodled2}), 32'd0);
        chk("r32_async_tick", 32'(tick), 32'd0);
        #2 rst_n = 1'b1;
        cycle();
        chk("r32_gnt", 32'(gnt), 32'b0010);
        cycle();
        chk("r32_led1", 32'(pmodled1), 32'(led_bits(8'hC3)));
        chk("r32_led2", 32'(pmodled2), 32'(led_bits(8'hA5)));

        // Random requests and pattern changes.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: pat0 = 16'($urandom);
                    1: pat1 = 16'($urandom);
                    2: pat2 = 16'($urandom);
                    default: pat3 = 16'($urandom);
                endcase
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pmod16led_arb.md
PMOD16LED_ARB -- requirements
Module: pmod16led_arb

Interface
REQ-001 The block SHALL expose parameter CLK_DIV, default 23'd6000000, giving the dwell-tick period in clk cycles (0.5 s at 12 MHz); legal range 2..2^23-1.
REQ-002 The block SHALL expose parameter HOLD_TICKS, default 4'd4, giving the minimum dwell in ticks before a granted source can be pre-empted; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-source display request; bit i belongs to source i.
REQ-006 pat0, pat1, pat2, pat3  input  16 each  LED pattern of source i.
REQ-007 pmodled1  output reg  [0:7]  LEDs D1-D8; pmodled1[k] = granted pattern bit k.
REQ-008 pmodled2  output reg  [0:7]  LEDs D9-D16; pmodled2[k] = granted pattern bit 8+k.
REQ-009 gnt  output reg  4  one-hot grant, or all zero when idle.
REQ-010 tick  output reg  1  one-cycle dwell-tick strobe.

Function
REQ-011 The prescaler SHALL be free-running, count 0..CLK_DIV-1 and wrap to 0, asserting tick for exactly the cycle after count equals CLK_DIV-1.
REQ-012 The FSM SHALL have two states, IDLE and SHOW; dwell is a 4-bit counter and last is a 2-bit index of the most recent grant.
REQ-013 Arbitration SHALL be round-robin: search req indices last+1, last+2, last+3, last (mod 4), and select the first index that is set.
REQ-014 In IDLE with req nonzero, the next cycle SHALL be SHOW, with gnt one-hot on the selected index, last equal to that index and dwell equal to 0.
REQ-015 In IDLE with req zero, the FSM SHALL remain in IDLE with gnt zero and LEDs zero.
REQ-016 In SHOW, dwell SHALL increment on each tick and saturate at HOLD_TICKS.
REQ-017 In SHOW, if the granted req bit is 0, the FSM SHALL re-arbitrate over the remaining requesters in the same cycle: on a hit, switch grant with dwell 0; on no hit, go to IDLE with gnt zero.
REQ-018 In SHOW, if dwell equals HOLD_TICKS and any other req bit is set, the grant SHALL rotate per REQ-013 and dwell SHALL be cleared to 0.
REQ-019 In SHOW, if dwell equals HOLD_TICKS and no other req bit is set, the grant SHALL be held with dwell saturated.
REQ-020 While dwell is below HOLD_TICKS, a still-requesting grantee SHALL NOT be pre-empted, regardless of other requests.
REQ-021 LED outputs SHALL be registered: in each cycle, pmodled1/pmodled2 hold the pattern of the source that gnt indicated in the previous cycle, and hold zero when the previous gnt was zero.
REQ-022 The pattern-to-LED latency SHALL therefore be one cycle after gnt, and pattern changes of the grantee SHALL propagate with one-cycle latency.
REQ-023 If a tick coincides with a grant change, the tick SHALL be consumed by the change and SHALL NOT increment the new dwell.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 When rst_n = 0, the block SHALL immediately and asynchronously clear prescaler, tick, dwell, gnt, pmodled1 and pmodled2 to 0, set the FSM to IDLE and set last to 3, so that source 0 has first priority.
REQ-026 Reset asserted mid-SHOW SHALL discard the grant with no LED residue.
REQ-027 The first arbitration after release SHALL follow REQ-014.

Verification (CLK_DIV=4, HOLD_TICKS=2)
REQ-028 Reset, then req=4'b0101 -> gnt=0001 on the first edge, and LEDs equal pat0 one cycle later.
REQ-029 req=4'b0011 held -> gnt alternates 0001/0010, each grant lasting 2 ticks plus at most 1 tick period, with tick every 4 cycles.
REQ-030 Grant on source 2, then req[2] drops at dwell 0 with req=4'b1000 -> gnt=1000 the next cycle with dwell 0; dropping all req -> gnt=0 and LEDs 0 one cycle later.
REQ-031 Single requester source 3 held for 20 ticks -> gnt stays 1000 with no glitch and dwell stays at 2.
REQ-032 rst_n pulsed low for half a cycle during SHOW with pat1=16'hA5C3 -> all outputs are 0 immediately; after release with req=4'b0010, gnt=0010, pmodled1=8'hC3 bit-mapped and pmodled2=8'hA5.
REQ-033 The bench SHALL check gnt one-hot-or-zero on every cycle and that no grantee is pre-empted while dwell < HOLD_TICKS.
